// File: rtl/rs_232_tx.sv
// rs_232_tx: UART transmitter, 8N1 frames (start, 8 data LSB first, stop),
// fed from a small circular byte FIFO so queued bytes go out back to back.
// Optional feature macro: PARITY_EN. When it is defined, an even-parity bit
// is inserted after D7 and each frame is 11 bits long.
module rs_232_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4,
  parameter int ADDR_W       = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data_in,
  input  logic       i_data_valid,
  output logic       o_ready,
  output logic       o_rs_232,
  output logic       o_busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_ready;

  // serializer state
  state_t            r_state;
  logic [CNT_W-1:0]  r_baud_cnt;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic              r_tx;
  logic              r_busy;
`ifdef PARITY_EN
  logic              r_parity;
`endif

  logic              w_push;
  logic              w_pop;
  logic              w_bit_end;
  logic [7:0]        w_head;
  logic [ADDR_W:0]   w_count_nxt;

  // r_ready is the registered "not full" flag, so a push while full is
  // refused even when a pop happens on the same edge.
  assign w_push    = i_data_valid && r_ready;
  assign w_bit_end = (r_baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
  // Pop either from IDLE or at the last cycle of STOP, so the next start bit
  // directly follows the stop bit.
  assign w_pop     = (r_count != '0) &&
                     ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
  assign w_head    = r_mem[r_rd_ptr];

  // Next FIFO occupancy; simultaneous push and pop leave it unchanged
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + (ADDR_W+1)'(1);
    else if (!w_push && w_pop)
      w_count_nxt = r_count - (ADDR_W+1)'(1);
  end

  // FIFO data write; contents need no reset since count gates every read
  always_ff @(posedge i_clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= i_data_in;
  end

  // FIFO pointers, count and registered ready
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != (ADDR_W+1)'(FIFO_DEPTH));
    end
  end

  // Frame FSM: line level and busy are registered so the output is glitch-free
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
`ifdef PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx       <= 1'b1;
          r_busy     <= 1'b0;
          r_baud_cnt <= '0;
          if (w_pop) begin
            r_shift   <= w_head;
`ifdef PARITY_EN
            r_parity  <= ^w_head;
`endif
            r_bit_idx <= '0;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_tx       <= r_shift[0];
            r_state    <= S_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
`ifdef PARITY_EN
              r_tx    <= r_parity;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end
`ifdef PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_tx       <= 1'b1;
            r_state    <= S_STOP;
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (w_pop) begin
              r_shift   <= w_head;
`ifdef PARITY_EN
              r_parity  <= ^w_head;
`endif
              r_bit_idx <= '0;
              r_tx      <= 1'b0;
              r_state   <= S_START;
            end else begin
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ready  = r_ready;
  assign o_rs_232 = r_tx;
  assign o_busy   = r_busy;

endmodule
